// File: rtl/aipp_t_thermal_inhibit_ctrl.sv
// rtl/aipp_t_thermal_inhibit_ctrl.sv - per-port thermal inhibit FSMs with hysteresis, dwell, ack tracking and round-robin budget
//
// Turns per-port temperature samples into the router's thermal_inhibit vector.
// Each output port runs COOL -> ASSERT -> HOT -> RELEASE -> COOL. The number of
// ports outside COOL is capped at MAX_INHIBIT, so the router always keeps at
// least one deflection target.
//
// Ports:
//   clk             clock, rising edge
//   rst             synchronous reset, active-high
//   temp_valid      temp_data valid this cycle
//   temp_data       packed temperatures, port p at [p*TEMP_WIDTH +: TEMP_WIDTH]
//   thermal_ack     router acknowledge per port, follows thermal_inhibit
//   clear_err       clears ack_err
//   thermal_inhibit registered inhibit per port (ASSERT or HOT)
//   inhibit_count   registered number of ports not in COOL
//   budget_denied   one-cycle pulse: a hot COOL port was held back by the budget
//   ack_err         sticky per-port ack timeout flags
module aipp_t_thermal_inhibit_ctrl #(
  parameter int NUM_PORTS    = 4,
  parameter int TEMP_WIDTH   = 8,
  parameter int HOT_THRESH   = 200,
  parameter int COOL_THRESH  = 180,
  parameter int DWELL_CYCLES = 16,
  parameter int ACK_TIMEOUT  = 8,
  parameter int MAX_INHIBIT  = 3,
  localparam int CNT_W = $clog2(NUM_PORTS + 1),
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int DW_W  = $clog2(DWELL_CYCLES + 1),
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            temp_valid,
  input  logic [NUM_PORTS*TEMP_WIDTH-1:0] temp_data,
  input  logic [NUM_PORTS-1:0]            thermal_ack,
  input  logic                            clear_err,
  output logic [NUM_PORTS-1:0]            thermal_inhibit,
  output logic [CNT_W-1:0]                inhibit_count,
  output logic                            budget_denied,
  output logic [NUM_PORTS-1:0]            ack_err
);

  typedef enum logic [1:0] {ST_COOL, ST_ASSERT, ST_HOT, ST_RELEASE} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  state_t                state_q [NUM_PORTS];
  logic [TEMP_WIDTH-1:0] temp_q  [NUM_PORTS];
  logic [DW_W-1:0]       dwell_q [NUM_PORTS];
  logic [TO_W-1:0]       tcnt_q  [NUM_PORTS];
  logic [PTR_W-1:0]      rr_ptr;

  logic [NUM_PORTS-1:0]  hot, cool, cand, grant_vec, ack_to, to_cool;
  logic [CNT_W-1:0]      occupied, to_cool_cnt, cnt_next;
  logic                  any_cand, can_grant, denied, found;
  logic [PTR_W-1:0]      scan_idx, winner_idx;

  // Grant, timeout and occupancy decisions all use the current state, so a
  // port finishing RELEASE this cycle frees its budget slot only next cycle.
  always_comb begin
    hot         = '0;
    cool        = '0;
    cand        = '0;
    grant_vec   = '0;
    ack_to      = '0;
    to_cool     = '0;
    occupied    = '0;
    to_cool_cnt = '0;
    found       = 1'b0;
    scan_idx    = '0;
    winner_idx  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      hot[p]  = temp_q[p] >= TEMP_WIDTH'(HOT_THRESH);
      cool[p] = temp_q[p] <= TEMP_WIDTH'(COOL_THRESH);
      if (state_q[p] != ST_COOL) occupied = occupied + CNT_W'(1);
      cand[p] = (state_q[p] == ST_COOL) && hot[p];
      case (state_q[p])
        ST_ASSERT:  ack_to[p] = !thermal_ack[p] && (tcnt_q[p] == TO_LAST);
        ST_RELEASE: begin
          ack_to[p]  = thermal_ack[p] && (tcnt_q[p] == TO_LAST);
          to_cool[p] = !thermal_ack[p] || ack_to[p];
        end
        default: ;
      endcase
      if (to_cool[p]) to_cool_cnt = to_cool_cnt + CNT_W'(1);
    end
    // Round-robin scan starting at rr_ptr, wrapping around.
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr) + k) % NUM_PORTS);
      if (!found && cand[scan_idx]) begin
        found      = 1'b1;
        winner_idx = scan_idx;
      end
    end
    any_cand  = |cand;
    can_grant = any_cand && (occupied < CNT_W'(MAX_INHIBIT));
    denied    = any_cand && !can_grant;
    if (can_grant) grant_vec[winner_idx] = 1'b1;
    // Occupancy after this edge: one possible new grant, minus ports leaving RELEASE.
    cnt_next = occupied + CNT_W'(can_grant) - to_cool_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= ST_COOL;
        temp_q[p]  <= '0;
        dwell_q[p] <= '0;
        tcnt_q[p]  <= '0;
      end
      rr_ptr          <= '0;
      thermal_inhibit <= '0;
      inhibit_count   <= '0;
      budget_denied   <= 1'b0;
      ack_err         <= '0;
    end else begin
      if (temp_valid) begin
        for (int p = 0; p < NUM_PORTS; p++) temp_q[p] <= temp_data[p*TEMP_WIDTH +: TEMP_WIDTH];
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        case (state_q[p])
          ST_COOL: begin
            if (grant_vec[p]) begin
              state_q[p]         <= ST_ASSERT;
              tcnt_q[p]          <= '0;
              thermal_inhibit[p] <= 1'b1;
            end
          end
          ST_ASSERT: begin
            // A missing ack still moves on to HOT; the error is flagged separately.
            if (thermal_ack[p] || ack_to[p]) begin
              state_q[p] <= ST_HOT;
              dwell_q[p] <= DW_W'(DWELL_CYCLES);
            end else begin
              tcnt_q[p] <= tcnt_q[p] + TO_W'(1);
            end
          end
          ST_HOT: begin
            if ((dwell_q[p] == '0) && cool[p]) begin
              state_q[p]         <= ST_RELEASE;
              tcnt_q[p]          <= '0;
              thermal_inhibit[p] <= 1'b0;
            end else if (dwell_q[p] != '0) begin
              dwell_q[p] <= dwell_q[p] - DW_W'(1);
            end
          end
          ST_RELEASE: begin
            if (to_cool[p]) state_q[p] <= ST_COOL;
            else            tcnt_q[p]  <= tcnt_q[p] + TO_W'(1);
          end
          default: begin
            state_q[p]         <= ST_COOL;
            thermal_inhibit[p] <= 1'b0;
          end
        endcase
      end
      // A timeout in the same cycle as clear_err keeps its bit set.
      ack_err       <= (clear_err ? {NUM_PORTS{1'b0}} : ack_err) | ack_to;
      inhibit_count <= cnt_next;
      budget_denied <= denied;
      if (can_grant) rr_ptr <= PTR_W'((int'(winner_idx) + 1) % NUM_PORTS);
    end
  end

endmodule
